phy_emu_tdp_ram_1clk: RTL and testbench

//  Single-clock true dual-port packet RAM for the PHY emulator rx/tx packet generators.

---
 rtl/phy_emu_tdp_ram_1clk.sv | 169 ++++++++++++++++
 tb/tb_phy_emu_tdp_ram_1clk.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/phy_emu_tdp_ram_1clk.sv
// Single-clock true dual-port packet RAM with byte enables, selectable read-during-write,
// A-priority write collisions, a collision counter and a post-reset clear sequencer.

// Per-port read pipeline: stage 0 captures the memory word, the last stage drives dout.
module phy_emu_tdp_ram_rd_pipe #(
    parameter int DATA_WIDTH = 64,
    parameter int RD_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dvld
);
    logic [RD_LATENCY-1:0]                 vld_pipe;
    logic [RD_LATENCY-1:0][DATA_WIDTH-1:0] dat_pipe;

    // Data stages load only behind a valid, so dout holds between results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe[0] <= rd_en;
            if (rd_en) dat_pipe[0] <= rd_data;
            for (int k = 1; k < RD_LATENCY; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                if (vld_pipe[k-1]) dat_pipe[k] <= dat_pipe[k-1];
            end
        end
    end

    assign dout = dat_pipe[RD_LATENCY-1];
    assign dvld = vld_pipe[RD_LATENCY-1];
endmodule

module phy_emu_tdp_ram_1clk #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 11,
    parameter int RD_LATENCY = 2,
    parameter int RDW_MODE   = 0,
    parameter int INIT_CLEAR = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en_a,
    input  logic                    we_a,
    input  logic [DATA_WIDTH/8-1:0] be_a,
    input  logic [ADDR_WIDTH-1:0]   addr_a,
    input  logic [DATA_WIDTH-1:0]   din_a,
    output logic [DATA_WIDTH-1:0]   dout_a,
    output logic                    dvld_a,
    input  logic                    en_b,
    input  logic                    we_b,
    input  logic [DATA_WIDTH/8-1:0] be_b,
    input  logic [ADDR_WIDTH-1:0]   addr_b,
    input  logic [DATA_WIDTH-1:0]   din_b,
    output logic [DATA_WIDTH-1:0]   dout_b,
    output logic                    dvld_b,
    output logic                    init_done,
    input  logic                    coll_clr,
    output logic [15:0]             coll_cnt
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    if (RD_LATENCY < 1 || RD_LATENCY > 3 || (DATA_WIDTH % 8) != 0) begin : g_param_chk
        $fatal(1, "phy_emu_tdp_ram_1clk: RD_LATENCY must be 1..3 and DATA_WIDTH a multiple of 8");
    end

    typedef enum logic {CLEAR, READY} state_t;
    localparam state_t RST_STATE = (INIT_CLEAR != 0) ? CLEAR : READY;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
    logic                  clr_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RST_STATE;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        clr_we     = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_we     = 1'b1;
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == '1) state_d = READY;
            end
            READY: ;
        endcase
    end

    assign init_done = (state_q == READY);

    // Port requests are dropped entirely until the clear sequence is done.
    logic wr_a, wr_b, same_addr, coll;
    logic [1:0] rd_en;
    assign wr_a      = init_done & en_a & we_a;
    assign wr_b      = init_done & en_b & we_b;
    assign rd_en[0]  = init_done & en_a & ~we_a;
    assign rd_en[1]  = init_done & en_b & ~we_b;
    assign same_addr = (addr_a == addr_b);
    assign coll      = init_done & en_a & en_b & same_addr & (we_a | we_b);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // B lanes are written first so an A lane on the same byte overrides it.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr_q] <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (wr_b && be_b[i]) mem[addr_b][8*i +: 8] <= din_b[8*i +: 8];
                if (wr_a && be_a[i]) mem[addr_a][8*i +: 8] <= din_a[8*i +: 8];
            end
        end
    end

    // In new-data mode the reader sees the other port's enabled lanes merged in.
    logic [1:0][DATA_WIDTH-1:0] rd_word;
    always_comb begin
        rd_word[0] = mem[addr_a];
        rd_word[1] = mem[addr_b];
        if (RDW_MODE != 0) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_b && same_addr && be_b[i]) rd_word[0][8*i +: 8] = din_b[8*i +: 8];
                if (wr_a && same_addr && be_a[i]) rd_word[1][8*i +: 8] = din_a[8*i +: 8];
            end
        end
    end

    logic [1:0][DATA_WIDTH-1:0] dout_p;
    logic [1:0]                 dvld_p;

    for (genvar p = 0; p < 2; p++) begin : g_port
        phy_emu_tdp_ram_rd_pipe #(
            .DATA_WIDTH (DATA_WIDTH),
            .RD_LATENCY (RD_LATENCY)
        ) u_rd_pipe (
            .clk     (clk),
            .rst_n   (rst_n),
            .rd_en   (rd_en[p]),
            .rd_data (rd_word[p]),
            .dout    (dout_p[p]),
            .dvld    (dvld_p[p])
        );
    end

    assign dout_a = dout_p[0];
    assign dout_b = dout_p[1];
    assign dvld_a = dvld_p[0];
    assign dvld_b = dvld_p[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         coll_cnt <= '0;
        else if (coll_clr)                  coll_cnt <= '0;
        else if (coll && coll_cnt != '1)    coll_cnt <= coll_cnt + 16'd1;
    end
endmodule

// File: tb/tb_phy_emu_tdp_ram_1clk.sv
// Scoreboard bench: two instances (old-data and new-data read-during-write) share stimulus;
// monitors pop expected read data and arrival cycle whenever a dvld pulse appears.
module tb_phy_emu_tdp_ram_1clk;
    localparam int DW = 64, AW = 4, NB = 8, LAT = 2;

    logic          clk = 1'b0, rst_n = 1'b1;
    logic          en_a = 0, we_a = 0, en_b = 0, we_b = 0, coll_clr = 0;
    logic [NB-1:0] be_a = '0, be_b = '0;
    logic [AW-1:0] addr_a = '0, addr_b = '0;
    logic [DW-1:0] din_a = '0, din_b = '0;

    logic [DW-1:0] dout_a0, dout_b0, dout_a1, dout_b1;
    logic          dvld_a0, dvld_b0, dvld_a1, dvld_b1, init_done0, init_done1;
    logic [15:0]   coll_cnt0, coll_cnt1;

    always #5 clk = ~clk;

    phy_emu_tdp_ram_1clk #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(LAT), .RDW_MODE(0), .INIT_CLEAR(1)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a0), .dvld_a(dvld_a0),
        .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b0), .dvld_b(dvld_b0),
        .init_done(init_done0), .coll_clr(coll_clr), .coll_cnt(coll_cnt0));

    phy_emu_tdp_ram_1clk #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(LAT), .RDW_MODE(1), .INIT_CLEAR(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a1), .dvld_a(dvld_a1),
        .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b1), .dvld_b(dvld_b1),
        .init_done(init_done1), .coll_clr(coll_clr), .coll_cnt(coll_cnt1));

    typedef struct { logic [DW-1:0] data; int cyc; } exp_t;
    exp_t q_a0[$], q_b0[$], q_a1[$], q_b1[$];
    int cyc = 0, nchk = 0, nerr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called at a negedge just before op(); the result lands LAT edges later.
    task automatic expect_a(input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        q_a0.push_back('{d0, cyc + LAT});
        q_a1.push_back('{d1, cyc + LAT});
    endtask
    task automatic expect_b(input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        q_b0.push_back('{d0, cyc + LAT});
        q_b1.push_back('{d1, cyc + LAT});
    endtask

    task automatic op(input logic ea, input logic wa, input logic [NB-1:0] ba, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                      input logic eb, input logic wb, input logic [NB-1:0] bb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
        en_a = ea; we_a = wa; be_a = ba; addr_a = aa; din_a = da;
        en_b = eb; we_b = wb; be_b = bb; addr_b = ab; din_b = db;
        @(negedge clk);
        en_a = 0; we_a = 0; en_b = 0; we_b = 0;
    endtask

    always @(negedge clk) if (dvld_a0) begin : mon_a0
        exp_t e;
        if (q_a0.size() == 0) chk("dvld_a0 unexpected", 1, 0);
        else begin e = q_a0.pop_front(); chk("dout_a0", dout_a0, e.data); chk("lat_a0", cyc, e.cyc); end
    end
    always @(negedge clk) if (dvld_b0) begin : mon_b0
        exp_t e;
        if (q_b0.size() == 0) chk("dvld_b0 unexpected", 1, 0);
        else begin e = q_b0.pop_front(); chk("dout_b0", dout_b0, e.data); chk("lat_b0", cyc, e.cyc); end
    end
    always @(negedge clk) if (dvld_a1) begin : mon_a1
        exp_t e;
        if (q_a1.size() == 0) chk("dvld_a1 unexpected", 1, 0);
        else begin e = q_a1.pop_front(); chk("dout_a1", dout_a1, e.data); chk("lat_a1", cyc, e.cyc); end
    end
    always @(negedge clk) if (dvld_b1) begin : mon_b1
        exp_t e;
        if (q_b1.size() == 0) chk("dvld_b1 unexpected", 1, 0);
        else begin e = q_b1.pop_front(); chk("dout_b1", dout_b1, e.data); chk("lat_b1", cyc, e.cyc); end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        #1 rst_n = 1'b0;
        #11;
        chk("rst dout_a", dout_a0, 0);
        chk("rst dvld_a", {63'd0, dvld_a0}, 0);
        chk("rst init_done", {63'd0, init_done0}, 0);
        chk("rst coll_cnt", coll_cnt0, 0);
        @(negedge clk) rst_n = 1'b1;

        k = 0;
        while (!init_done0 && k < 100) begin @(negedge clk); k++; end
        chk("init_done cycles", k, 16);
        chk("init_done1", {63'd0, init_done1}, 1);

        // Whole array reads back zero; B walks the addresses in reverse.
        for (int i = 0; i < 16; i++) begin
            expect_a(0, 0);
            expect_b(0, 0);
            op(1, 0, 8'h00, 4'(i), 0, 1, 0, 8'h00, 4'(15 - i), 0);
        end

        op(1, 1, 8'hFF, 4'd5, 64'h1122334455667788, 0, 0, 0, 0, 0);
        expect_a(64'h1122334455667788, 64'h1122334455667788);
        op(1, 0, 0, 4'd5, 0, 0, 0, 0, 0, 0);
        repeat (4) @(negedge clk);
        chk("dout_a hold", dout_a0, 64'h1122334455667788);
        chk("dvld_a idle", {63'd0, dvld_a0}, 0);

        op(0, 0, 0, 0, 0, 1, 1, 8'hFF, 4'd9, 64'hFFFFFFFFFFFFFFFF);
        op(1, 1, 8'h0F, 4'd9, 64'h0, 0, 0, 0, 0, 0);
        expect_b(64'hFFFFFFFF00000000, 64'hFFFFFFFF00000000);
        op(0, 0, 0, 0, 0, 1, 0, 0, 4'd9, 0);
        chk("coll_cnt before", coll_cnt0, 0);

        op(1, 1, 8'h0F, 4'd3, {8{8'hAA}}, 1, 1, 8'hFF, 4'd3, {8{8'hBB}});
        expect_a(64'hBBBBBBBBAAAAAAAA, 64'hBBBBBBBBAAAAAAAA);
        op(1, 0, 0, 4'd3, 0, 0, 0, 0, 0, 0);
        chk("coll_cnt ww", coll_cnt0, 1);

        expect_b(64'h0, 64'h55);
        op(1, 1, 8'hFF, 4'd7, 64'h55, 1, 0, 0, 4'd7, 0);
        chk("coll_cnt rdw", coll_cnt0, 2);
        chk("coll_cnt1 rdw", coll_cnt1, 2);
        expect_a(64'h55, 64'h55);
        op(1, 0, 0, 4'd7, 0, 0, 0, 0, 0, 0);

        op(1, 1, 8'h00, 4'd5, 64'h0, 0, 0, 0, 0, 0);
        expect_b(64'h1122334455667788, 64'h1122334455667788);
        op(0, 0, 0, 0, 0, 1, 0, 0, 4'd5, 0);

        // Clear wins over the increment of a simultaneous collision.
        coll_clr = 1'b1;
        expect_a(64'h0, 64'h77);
        op(1, 0, 0, 4'd2, 0, 1, 1, 8'hFF, 4'd2, 64'h77);
        coll_clr = 1'b0;
        chk("coll_cnt clr", coll_cnt0, 0);
        expect_a(64'h77, 64'h77);
        expect_b(64'h77, 64'h77);
        op(1, 0, 0, 4'd2, 0, 1, 0, 0, 4'd2, 0);
        chk("coll_cnt rr", coll_cnt0, 0);

        op(1, 1, 8'hFF, 4'd4, 64'h1, 1, 1, 8'hFF, 4'd4, 64'h2);
        chk("coll_cnt pre-rst", coll_cnt0, 1);
        repeat (4) @(negedge clk);

        // Reset during clear, then requests issued during the restarted clear are ignored.
        rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #2;
        chk("mid rst init_done", {63'd0, init_done0}, 0);
        chk("mid rst coll_cnt", coll_cnt0, 0);
        chk("mid rst dout_a", dout_a0, 0);
        @(negedge clk) rst_n = 1'b1;
        k = 0;
        repeat (3) begin @(negedge clk); k++; end
        op(1, 1, 8'hFF, 4'd1, 64'hDEAD, 1, 0, 0, 4'd1, 0); k++;
        op(1, 0, 0, 4'd0, 0, 1, 0, 0, 4'd5, 0); k++;
        while (!init_done0 && k < 100) begin @(negedge clk); k++; end
        chk("restart cycles", k, 16);
        chk("coll_cnt clear phase", coll_cnt0, 0);

        expect_a(0, 0); expect_b(0, 0);
        op(1, 0, 0, 4'd1, 0, 1, 0, 0, 4'd9, 0);
        expect_a(0, 0); expect_b(0, 0);
        op(1, 0, 0, 4'd5, 0, 1, 0, 0, 4'd3, 0);

        repeat (6) @(negedge clk);
        chk("q_a0 drained", q_a0.size(), 0);
        chk("q_b0 drained", q_b0.size(), 0);
        chk("q_a1 drained", q_a1.size(), 0);
        chk("q_b1 drained", q_b1.size(), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
